// File: rtl/player_controller_gen_if.sv
// Player controller bus: tick strobes and buttons in, position/state/pulses out.
interface player_controller_gen_if #(
  parameter int unsigned POS_W = 6
) ();
  logic [1:0]       game_tick;
  logic             button_up;
  logic             button_down;
  logic             crash;
  logic [POS_W-1:0] player_position;
  logic             game_start_pulse;
  logic             game_over_pulse;
  logic             jump_pulse;
  logic             jumping;
  logic             ducking;
  logic [2:0]       state;

  modport master (
    output game_tick, button_up, button_down, crash,
    input  player_position, game_start_pulse, game_over_pulse, jump_pulse,
           jumping, ducking, state
  );

  modport slave (
    input  game_tick, button_up, button_down, crash,
    output player_position, game_start_pulse, game_over_pulse, jump_pulse,
           jumping, ducking, state
  );
endinterface

// File: rtl/player_controller_gen.sv
// Runner-game player controller: run/duck/jump/game-over FSM with jump physics,
// a jump buffer for early presses and a restart hold-off after game over.
module player_controller_gen #(
  parameter int unsigned POS_W         = 6,
  parameter int unsigned JUMP_VEL      = 7,
  parameter int unsigned GRAVITY       = 1,
  parameter int unsigned BUF_TICKS     = 3,
  parameter int unsigned HOLDOFF_TICKS = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  player_controller_gen_if.slave bus
);

  localparam int unsigned VEL_W  = POS_W + 2;
  localparam int unsigned SUM_W  = POS_W + 3;
  localparam int unsigned BUF_W  = (BUF_TICKS < 1) ? 1 : $clog2(BUF_TICKS + 1);
  localparam int unsigned HOLD_W = (HOLDOFF_TICKS < 1) ? 1 : $clog2(HOLDOFF_TICKS + 1);

  localparam logic signed [VEL_W-1:0] JUMP_V = VEL_W'(JUMP_VEL);
  localparam logic signed [VEL_W-1:0] G1     = VEL_W'(GRAVITY);
  localparam logic signed [VEL_W-1:0] G2     = VEL_W'(2 * GRAVITY);
  localparam logic [POS_W-1:0]        POS_MAX = '1;
  localparam logic [BUF_W-1:0]        BUF_LOAD  = BUF_W'(BUF_TICKS);
  localparam logic [HOLD_W-1:0]       HOLD_LOAD = HOLD_W'(HOLDOFF_TICKS);

  typedef enum logic [2:0] {
    RESTART   = 3'd0,
    JUMPING   = 3'd1,
    RUNNING   = 3'd2,
    DUCKING   = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [POS_W-1:0]          pos_q;
  logic signed [VEL_W-1:0]   vel_q;
  logic [BUF_W-1:0]          buf_q;
  logic [HOLD_W-1:0]         hold_q;

  logic                      tick0, tick1;
  logic signed [SUM_W-1:0]   next_sum;
  logic                      next_le0, vel_le0, over_max, land_cond;
  logic                      launch, start, go_enter, rebound, phys;

  assign tick0 = bus.game_tick[0];
  assign tick1 = bus.game_tick[1];

  // Candidate height for this physics tick and its landing/clamp conditions.
  always_comb begin
    next_sum  = $signed({3'b000, pos_q}) + $signed({vel_q[VEL_W-1], vel_q});
    next_le0  = next_sum[SUM_W-1] || (next_sum == '0);
    vel_le0   = vel_q[VEL_W-1] || (vel_q == '0);
    over_max  = !next_sum[SUM_W-1] && (next_sum[SUM_W-2:POS_W] != '0);
    land_cond = tick1 && next_le0 && vel_le0;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= RESTART;
    else          state_q <= state_d;
  end

  // Next-state logic plus the transition strobes the datapath and pulses use.
  always_comb begin
    state_d  = state_q;
    launch   = 1'b0;
    start    = 1'b0;
    go_enter = 1'b0;
    rebound  = 1'b0;
    case (state_q)
      RESTART: begin
        if (tick0 && bus.button_up) begin
          state_d = JUMPING;
          launch  = 1'b1;
          start   = 1'b1;
        end
      end
      RUNNING: begin
        if (tick0) begin
          if (bus.crash) begin
            state_d  = GAME_OVER;
            go_enter = 1'b1;
          end else if (bus.button_down) begin
            state_d = DUCKING;
          end else if (bus.button_up) begin
            state_d = JUMPING;
            launch  = 1'b1;
          end
        end
      end
      DUCKING: begin
        if (tick0) begin
          if (bus.crash) begin
            state_d  = GAME_OVER;
            go_enter = 1'b1;
          end else if (!bus.button_down) begin
            state_d = RUNNING;
          end
        end
      end
      JUMPING: begin
        // A crash on tick0 pre-empts any landing on the same cycle.
        if (tick0 && bus.crash) begin
          state_d  = GAME_OVER;
          go_enter = 1'b1;
        end else if (land_cond) begin
          if (buf_q != '0) rebound = 1'b1;
          else             state_d = RUNNING;
        end
      end
      GAME_OVER: begin
        if (tick0 && bus.button_up && (hold_q == '0)) state_d = RUNNING;
      end
      default: state_d = RESTART;
    endcase
  end

  assign phys = (state_q == JUMPING) && tick1 && !go_enter;

  // Height and velocity: launch, ballistic update, landing/rebound, ground clamp.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q <= '0;
      vel_q <= '0;
    end else begin
      if (launch) begin
        vel_q <= JUMP_V;
      end else if (phys) begin
        if (land_cond) begin
          pos_q <= '0;
          vel_q <= rebound ? JUMP_V : '0;
        end else begin
          pos_q <= over_max ? POS_MAX : next_sum[POS_W-1:0];
          vel_q <= vel_q - (bus.button_down ? G2 : G1);
        end
      end
      // Game over keeps the crash height on display; every other non-jump state sits on the ground.
      if (state_d != JUMPING && state_d != GAME_OVER) pos_q <= '0;
    end
  end

  // Jump buffer and game-over hold-off counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      buf_q  <= '0;
      hold_q <= '0;
    end else begin
      // A fresh press outranks the consumption by a rebound on the same cycle.
      if ((state_q == JUMPING) && tick0 && bus.button_up) buf_q <= BUF_LOAD;
      else if (rebound)                                   buf_q <= '0;
      else if (tick0 && (buf_q != '0))                    buf_q <= buf_q - BUF_W'(1);

      if (go_enter)                     hold_q <= HOLD_LOAD;
      else if (tick0 && (hold_q != '0)) hold_q <= hold_q - HOLD_W'(1);
    end
  end

  // Outputs: state decodes and transition pulses, pulses forced low during reset.
  always_comb begin
    bus.state            = state_q;
    bus.player_position  = pos_q;
    bus.jumping          = (state_q == JUMPING);
    bus.ducking          = (state_q == DUCKING);
    bus.game_start_pulse = reset_n & start;
    bus.game_over_pulse  = reset_n & go_enter;
    bus.jump_pulse       = reset_n & (launch | rebound);
  end

endmodule
